// File: rtl/cu_seq_if.sv
// Sequencer <-> control memory / IR / datapath-flag bundle.
// master: the sequencer; slave: the control memory and IR side.
interface cu_seq_if;
  localparam int unsigned CW_W    = 24;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned ICNT_W  = 16;
  localparam int unsigned CCNT_W  = 32;

  logic [CW_W-1:0]   control_word;
  logic [OP_W-1:0]   opcode;
  logic              ind;
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] car;
  logic              running;
  logic              halted;
  logic              err;
  logic [ICNT_W-1:0] instr_count;
  logic [CCNT_W-1:0] cycle_count;

  modport master (
    input  control_word, opcode, ind, start, stall,
    output car, running, halted, err, instr_count, cycle_count
  );

  modport slave (
    output control_word, opcode, ind, start, stall,
    input  car, running, halted, err, instr_count, cycle_count
  );
endinterface

// File: rtl/cu_sequencer.sv
// Microprogram sequencer: owns the CAR, dispatches opcodes, handles the indirect
// detour, halt and trap. Performance counters are built only with CU_SEQ_PERF_EN.
module cu_sequencer (
  input  logic     clk,
  input  logic     rst,
  cu_seq_if.master bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_TRAP   = 2'd3;

  localparam logic [3:0] SEQ_DISPATCH = 4'b0001;
  localparam logic [3:0] SEQ_INC      = 4'b0010;
  localparam logic [3:0] SEQ_RETURN   = 4'b0011;

  localparam logic [7:0] CAR_FETCH = 8'h00;
  localparam logic [7:0] CAR_IND   = 8'h05;
  localparam logic [7:0] CAR_HALT  = 8'h16;
  localparam logic [7:0] CAR_TRAP  = 8'hFF;

  logic [1:0] state_q, state_nxt;
  logic [7:0] car_q, car_nxt;
  logic [7:0] op_q, op_nxt;
  logic       ind_pend_q, ind_pend_nxt;
  logic       halt_pend_q, halt_pend_nxt;
  logic       err_q, err_nxt;
  logic       running_q, halted_q;
  logic       instr_inc;
  logic       trap;
  logic [3:0] seq;
  logic [8:0] map_new, map_lat;
  logic       unused_cw;

  // Opcode -> EX entry address; bit 8 flags a valid mapping.
  function automatic logic [8:0] map_op(input logic [7:0] op);
    case (op)
      8'h01:   map_op = {1'b1, 8'h07};
      8'h02:   map_op = {1'b1, 8'h09};
      8'h03:   map_op = {1'b1, 8'h0B};
      8'h04:   map_op = {1'b1, 8'h0D};
      8'h05:   map_op = {1'b1, 8'h12};
      8'h06:   map_op = {1'b1, 8'h14};
      8'h07:   map_op = {1'b1, 8'h16};
      8'h08:   map_op = {1'b1, 8'h10};
      8'h0A:   map_op = {1'b1, 8'h18};
      8'h0B:   map_op = {1'b1, 8'h1A};
      8'h0C:   map_op = {1'b1, 8'h1C};
      8'h0D:   map_op = {1'b1, 8'h1E};
      8'h0E:   map_op = {1'b1, 8'h20};
      default: map_op = 9'h000;
    endcase
  endfunction

  assign seq       = bus.control_word[23:20];
  assign unused_cw = ^bus.control_word[19:0];
  assign map_new   = map_op(bus.opcode);
  assign map_lat   = map_op(op_q);

  // Next-state and next-CAR decision.
  always_comb begin
    state_nxt     = state_q;
    car_nxt       = car_q;
    op_nxt        = op_q;
    ind_pend_nxt  = ind_pend_q;
    halt_pend_nxt = halt_pend_q;
    err_nxt       = err_q;
    instr_inc     = 1'b0;
    trap          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        car_nxt = CAR_FETCH;
        if (bus.start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.stall) begin
          case (seq)
            SEQ_INC: car_nxt = car_q + 8'd1;
            SEQ_DISPATCH: begin
              op_nxt = bus.opcode;
              if (bus.ind) begin
                car_nxt      = CAR_IND;
                ind_pend_nxt = 1'b1;
              end else if (map_new[8]) begin
                car_nxt = map_new[7:0];
                if (map_new[7:0] == CAR_HALT) halt_pend_nxt = 1'b1;
              end else begin
                trap = 1'b1;
              end
            end
            SEQ_RETURN: begin
              if (ind_pend_q) begin
                ind_pend_nxt = 1'b0;
                if (map_lat[8]) begin
                  car_nxt = map_lat[7:0];
                  if (map_lat[7:0] == CAR_HALT) halt_pend_nxt = 1'b1;
                end else begin
                  trap = 1'b1;
                end
              end else begin
                car_nxt   = CAR_FETCH;
                instr_inc = 1'b1;
                // Halt parks on the return address so it stays observable.
                if (halt_pend_q) begin
                  state_nxt     = ST_HALTED;
                  car_nxt       = car_q;
                  halt_pend_nxt = 1'b0;
                end
              end
            end
            default: trap = 1'b1;
          endcase
        end
      end
      ST_HALTED: begin
        if (bus.start) begin
          car_nxt   = CAR_FETCH;
          state_nxt = ST_RUN;
        end
      end
      default: ;
    endcase
    if (trap) begin
      state_nxt = ST_TRAP;
      car_nxt   = CAR_TRAP;
      err_nxt   = 1'b1;
    end
  end

  // State, CAR, pending flags and registered state decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      car_q       <= CAR_FETCH;
      op_q        <= 8'h00;
      ind_pend_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      err_q       <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      car_q       <= car_nxt;
      op_q        <= op_nxt;
      ind_pend_q  <= ind_pend_nxt;
      halt_pend_q <= halt_pend_nxt;
      err_q       <= err_nxt;
      running_q   <= (state_nxt == ST_RUN);
      halted_q    <= (state_nxt == ST_HALTED);
    end
  end

  assign bus.car     = car_q;
  assign bus.running = running_q;
  assign bus.halted  = halted_q;
  assign bus.err     = err_q;

`ifdef CU_SEQ_PERF_EN
  logic [15:0] instr_q;
  logic [31:0] cycle_q;

  // Cycle count includes stalled RUN cycles; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= 16'd0;
      cycle_q <= 32'd0;
    end else begin
      if (instr_inc)          instr_q <= instr_q + 16'd1;
      if (state_q == ST_RUN)  cycle_q <= cycle_q + 32'd1;
    end
  end

  assign bus.instr_count = instr_q;
  assign bus.cycle_count = cycle_q;
`else
  logic unused_perf;
  assign unused_perf     = instr_inc;
  assign bus.instr_count = 16'd0;
  assign bus.cycle_count = 32'd0;
`endif
endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: cycle vectors against a small microprogram ROM,
// then hand sequences for counters, stall and asynchronous reset.
module tb_cu_sequencer;
  typedef struct {
    logic       rst, start, stall;
    logic [7:0] opcode;
    logic       ind;
    logic [7:0] car;
    logic       running, halted, err;
  } vec_t;

`ifdef CU_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic clk      = 1'b0;
  logic rst      = 1'b1;

  cu_seq_if bus();

  cu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Microprogram sequencing nibbles; unlisted addresses are unpopulated (0).
  function automatic logic [3:0] cm_seq(input logic [7:0] a);
    case (a)
      8'h00, 8'h01, 8'h02, 8'h03: cm_seq = 4'b0010;
      8'h04:                      cm_seq = 4'b0001;
      8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h10, 8'h16: cm_seq = 4'b0010;
      8'h06, 8'h08, 8'h0A, 8'h0C, 8'h11, 8'h12, 8'h14, 8'h17,
      8'h18, 8'h1A, 8'h1C, 8'h1E, 8'h20:               cm_seq = 4'b0011;
      default:                    cm_seq = 4'b0000;
    endcase
  endfunction

  always_comb bus.control_word = {cm_seq(bus.car), 20'h5A3C1};

  task automatic add(input logic r, input logic s, input logic st, input logic [7:0] op,
                     input logic i, input logic [7:0] c, input logic ru, input logic h,
                     input logic e);
    vec_t v;
    v.rst = r; v.start = s; v.stall = st; v.opcode = op; v.ind = i;
    v.car = c; v.running = ru; v.halted = h; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic add_run(input logic [7:0] op, input logic i, input logic [7:0] c);
    add(1'b0, 1'b0, 1'b0, op, i, c, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic st, input logic [7:0] op,
                      input logic i);
    rst = r; bus.start = s; bus.stall = st; bus.opcode = op; bus.ind = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0; bus.stall = 1'b0; bus.opcode = 8'h00; bus.ind = 1'b0;

    // Reset, idle, start
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h03, 0, 8'h00, 1, 0, 0);
    // ADD direct
    add_run(8'h03, 0, 8'h01); add_run(8'h03, 0, 8'h02); add_run(8'h03, 0, 8'h03);
    add_run(8'h03, 0, 8'h04); add_run(8'h03, 0, 8'h0B); add_run(8'h03, 0, 8'h0C);
    add_run(8'h03, 0, 8'h00);
    // LOAD indirect
    add_run(8'h02, 1, 8'h01); add_run(8'h02, 1, 8'h02); add_run(8'h02, 1, 8'h03);
    add_run(8'h02, 1, 8'h04); add_run(8'h02, 1, 8'h05); add_run(8'h02, 1, 8'h06);
    add_run(8'h02, 1, 8'h09); add_run(8'h02, 1, 8'h0A); add_run(8'h02, 1, 8'h00);
    // STORE with a 3-cycle stall at 0x02
    add_run(8'h01, 0, 8'h01); add_run(8'h01, 0, 8'h02);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 8'h01, 0, 8'h02, 1, 0, 0);
    add_run(8'h01, 0, 8'h03); add_run(8'h01, 0, 8'h04); add_run(8'h01, 0, 8'h07);
    add_run(8'h01, 0, 8'h08); add_run(8'h01, 0, 8'h00);
    // HALT, hold 10 cycles, restart with start+stall together
    add_run(8'h07, 0, 8'h01); add_run(8'h07, 0, 8'h02); add_run(8'h07, 0, 8'h03);
    add_run(8'h07, 0, 8'h04); add_run(8'h07, 0, 8'h16); add_run(8'h07, 0, 8'h17);
    add(0, 0, 0, 8'h07, 0, 8'h17, 0, 1, 0);
    for (int k = 0; k < 10; k++) add(0, 0, k[0], 8'h07, 0, 8'h17, 0, 1, 0);
    add(0, 1, 1, 8'h03, 0, 8'h00, 1, 0, 0);
    // ADD after restart completes normally (halt_pend was cleared)
    add_run(8'h03, 0, 8'h01); add_run(8'h03, 0, 8'h02); add_run(8'h03, 0, 8'h03);
    add_run(8'h03, 0, 8'h04); add_run(8'h03, 0, 8'h0B); add_run(8'h03, 0, 8'h0C);
    add_run(8'h03, 0, 8'h00);
    // SUB runs into unpopulated 0x0E; start in RUN ignored
    add(0, 1, 0, 8'h04, 0, 8'h01, 1, 0, 0);
    add_run(8'h04, 0, 8'h02); add_run(8'h04, 0, 8'h03); add_run(8'h04, 0, 8'h04);
    add_run(8'h04, 0, 8'h0D); add_run(8'h04, 0, 8'h0E);
    add(0, 0, 0, 8'h04, 0, 8'hFF, 0, 0, 1);
    add(0, 1, 0, 8'h04, 0, 8'hFF, 0, 0, 1);
    add(0, 0, 1, 8'h04, 0, 8'hFF, 0, 0, 1);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h09, 1, 8'h00, 1, 0, 0);
    // Unmapped opcode via the indirect return
    add_run(8'h09, 1, 8'h01); add_run(8'h09, 1, 8'h02); add_run(8'h09, 1, 8'h03);
    add_run(8'h09, 1, 8'h04); add_run(8'h09, 1, 8'h05); add_run(8'h09, 1, 8'h06);
    add(0, 0, 0, 8'h09, 1, 8'hFF, 0, 0, 1);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h09, 0, 8'h00, 1, 0, 0);
    // Unmapped opcode at direct dispatch
    add_run(8'h09, 0, 8'h01); add_run(8'h09, 0, 8'h02); add_run(8'h09, 0, 8'h03);
    add_run(8'h09, 0, 8'h04);
    add(0, 0, 0, 8'h09, 0, 8'hFF, 0, 0, 1);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].opcode, vecs[i].ind);
      check($sformatf("vec%0d car/run/halt/err", i),
            {21'd0, bus.car, bus.running, bus.halted, bus.err},
            {21'd0, vecs[i].car, vecs[i].running, vecs[i].halted, vecs[i].err});
    end

    // Counters across ADD, then a stall, then async reset mid-ADD
    step(1, 0, 0, 8'h03, 0);
    check("rst instr_count", 32'(bus.instr_count), 32'd0);
    check("rst cycle_count", bus.cycle_count, 32'd0);
    step(0, 1, 0, 8'h03, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 8'h03, 0);
    check("add car", 32'(bus.car), 32'h00);
    check("add instr_count", 32'(bus.instr_count), PERF ? 32'd1 : 32'd0);
    check("add cycle_count", bus.cycle_count, PERF ? 32'd7 : 32'd0);
    step(0, 0, 0, 8'h03, 0);
    step(0, 0, 0, 8'h03, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 8'h03, 0);
    check("stall car", 32'(bus.car), 32'h02);
    check("stall instr_count", 32'(bus.instr_count), PERF ? 32'd1 : 32'd0);
    check("stall cycle_count", bus.cycle_count, PERF ? 32'd12 : 32'd0);
    step(0, 0, 0, 8'h03, 0);
    check("resume car", 32'(bus.car), 32'h03);
    step(0, 0, 0, 8'h03, 0);
    step(0, 0, 0, 8'h03, 0);
    check("mid-add car", 32'(bus.car), 32'h0B);
    #1 rst = 1'b1;
    #1;
    check("async rst car", 32'(bus.car), 32'h00);
    check("async rst flags", {29'd0, bus.running, bus.halted, bus.err}, 32'd0);
    check("async rst counters", bus.cycle_count | 32'(bus.instr_count), 32'd0);
    step(0, 0, 0, 8'h00, 0);
    check("idle after rst", {21'd0, bus.car, bus.running, bus.halted, bus.err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Microprogram sequencer for the control unit: owns the control address register (CAR) that drives the combinational control memory, and reads back the 24-bit control word to compute the next microaddress. Instruction dispatch happens here: map the IR opcode, handle the indirect-addressing detour, and enter halt or trap. The block sits between the IR/datapath flag inputs and the control-memory address port; the rest of the control word passes through to the datapath untouched.

## Interface
- No parameters. All widths are fixed by the control-word format.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- control_word  input  24  current word from control memory; only [23:20] (sequencing field) is consumed
- opcode  input  8  IR opcode, stable from ID2 onward
- ind  input  1  IR indirect-address bit, sampled at dispatch
- start  input  1  single-cycle pulse; leaves IDLE or HALTED
- stall  input  1  memory not ready; freeze CAR and state
- car  output  8  control address register to control memory
- running  output  1  high in RUN state
- halted  output  1  high in HALTED state
- err  output  1  sticky trap flag
- instr_count  output  16  completed instructions (see Configuration)
- cycle_count  output  32  RUN-state cycles (see Configuration)

## Operation
- States: IDLE, RUN, HALTED, TRAP. Encoding is free.
- Sequencing field seq = control_word[23:20]. It is evaluated only in RUN with stall=0.
  - 4'b0010 INC: car <= car+1.
  - 4'b0001 DISPATCH: if ind=1, car <= 0x05 and set ind_pend. Otherwise car <= map(opcode).
  - 4'b0011 RETURN:
    - If ind_pend=1: car <= map(latched opcode), clear ind_pend.
    - Else: car <= 0x00 and instr_count+1. If halt_pend=1, go to HALTED and hold car.
  - Any other value (including 4'b0000 from an unpopulated address such as 0x0E): go to TRAP, car <= 0xFF, err <= 1.
- Opcode map (EX entry): 0x01→0x07 STORE, 0x02→0x09 LOAD, 0x03→0x0B ADD, 0x04→0x0D SUB, 0x05→0x12 JMPGEZ, 0x06→0x14 JUMP, 0x07→0x16 HALT, 0x08→0x10 MPY, 0x0A→0x18 AND, 0x0B→0x1A OR, 0x0C→0x1C NOT, 0x0D→0x1E SHIFTR, 0x0E→0x20 SHIFTL.
  - Any unmapped opcode at DISPATCH or at an indirect RETURN goes to TRAP.
- The opcode is latched at DISPATCH. The indirect RETURN uses the latched value.
- halt_pend is set when the mapped target is 0x16. It is cleared on entry to HALTED.
- IDLE: car=0x00. start goes to RUN.
- HALTED: car holds. start sets car <= 0x00 and goes to RUN. halt_pend and ind_pend are already clear.
- TRAP: exited only by rst. start is ignored.
- stall=1 in RUN freezes car, the pending flags and instr_count. cycle_count still increments.
- In IDLE, HALTED and TRAP, stall has no effect.
- Counters wrap modulo 2^16 / 2^32 with no saturation.

## Timing
- car is registered; control_word is combinational on car. One microinstruction per unstalled RUN cycle.
- Next-car decision to new car visible: one clk edge. There is no other latency.
- Reset values (asynchronous): car=0x00, state IDLE, running=0, halted=0, err=0, ind_pend=0, halt_pend=0, instr_count=0, cycle_count=0.
- rst mid-instruction aborts immediately. Pending flags are discarded.
- start in the same cycle as stall while in IDLE or HALTED: start wins.
- start while in RUN: ignored.
- running, halted and err are registered state decodes. They change on the same edge as the state.
- ADD takes 7 cycles IDLE→return: IF1, IF2, ID1, ID2, FO, EX, WB. The indirect form adds 2 cycles.

## Configuration
- CU_SEQ_PERF_EN defined: instr_count and cycle_count registers are implemented as specified.
- CU_SEQ_PERF_EN undefined: both outputs are tied to 0 and no counter flops are inferred. Sequencing behaviour is identical.

## Test plan
- Reset, start, ADD (opcode 0x03, ind=0) -> car sequence 00,01,02,03,04,0B,0C,00. instr_count=1 after 7 RUN cycles.
- LOAD (opcode 0x02, ind=1) -> car 00..04,05,06,09,0A,00. instr_count increments once, at the final return only.
- HALT (opcode 0x07) -> car reaches 0x17, then halted=1 with car held 0x17 for 10 cycles. A start pulse gives car=00 and running=1.
- stall held 3 cycles at car=0x02 -> car stays 0x02. cycle_count +3, instr_count unchanged. Sequence resumes 03,04.
- Opcode 0x09 at dispatch -> TRAP, car=0xFF, err=1. start is ignored. rst clears err and car to 0x00.
- Assert rst at car=0x0B mid-ADD -> car=0x00 and state IDLE asynchronously, before the next clk edge.
